// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and host onto single-port data memory; write gnt +1 cycle, read rvalid +2 cycles.
// Backpressure: requesters hold req until gnt; cpu_stall freezes the PC while a CPU access is pending.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int POLICY     = 0,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    state_t        state_q, state_d;
    logic          owner_host_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    starve_cnt_q;
    logic          last_host_q;
    logic          any_req;
    logic          host_wins;
    logic          in_issue;
    logic          in_resp;

    assign any_req = cpu_req | host_req;

    always_comb begin
        host_wins = 1'b0;
        if (host_req && !cpu_req) begin
            host_wins = 1'b1;
        end else if (host_req && cpu_req) begin
            if (POLICY == 1) begin
                host_wins = ~last_host_q;
            end else begin
                host_wins = (starve_cnt_q == LIM);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? ISSUE : IDLE;
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured only at the IDLE decision so later changes cannot leak into an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_host_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_host_q  <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            owner_host_q <= host_wins;
            we_q         <= host_wins ? host_we : cpu_we;
            addr_q       <= host_wins ? host_addr : cpu_addr;
            wdata_q      <= host_wins ? host_wdata : cpu_wdata;
            last_host_q  <= host_wins;
        end
    end

    // Counts consecutive host losses while it waits; saturates so the host wins on the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (!host_req || host_wins) begin
                starve_cnt_q <= 8'd0;
            end else if (cpu_req && starve_cnt_q != LIM) begin
                starve_cnt_q <= starve_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        in_issue    = (state_q == ISSUE);
        in_resp     = (state_q == RESP);
        mem_en      = in_issue;
        mem_we      = in_issue & we_q;
        mem_addr    = in_issue ? addr_q : '0;
        mem_wdata   = in_issue ? wdata_q : '0;
        cpu_gnt     = in_issue & ~owner_host_q;
        host_gnt    = in_issue & owner_host_q;
        cpu_rvalid  = in_resp & ~owner_host_q;
        host_rvalid = in_resp & owner_host_q;
        cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

    assign cpu_stall = cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives a fixed-priority (index 0) and a round-robin (index 1) arbiter with independent requesters
// and checks every cycle against a transaction-level schedule model and a shadow memory.
module tb_dmem_arbiter;
    localparam int LIM = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       cpu_req, cpu_we, host_req, host_we;
    logic [1:0][31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic [1:0]       cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
    logic [1:0]       mem_en, mem_we;
    logic [1:0][31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0]      tbmem [2][16];

    int checks, errors, cyc;
    bit hold_on, rnd_on, rec;

    // Reference model: when the arbiter is free, the winner's access is scheduled at fixed offsets.
    int          free_at [2];
    int          iss_cyc [2];
    int          h_lost  [2];
    bit          iss_host[2], iss_we[2], last_host[2];
    logic [31:0] iss_addr[2], iss_wd[2], rsp_data[2];
    logic [31:0] shadow  [2][16];
    logic [9:0]  gseq    [2];
    int          gcnt    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.AW(32), .DW(32), .POLICY(g), .STARVE_LIM(LIM)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpu_req    (cpu_req[g]),
            .cpu_we     (cpu_we[g]),
            .cpu_addr   (cpu_addr[g]),
            .cpu_wdata  (cpu_wdata[g]),
            .cpu_gnt    (cpu_gnt[g]),
            .cpu_rvalid (cpu_rvalid[g]),
            .cpu_rdata  (cpu_rdata[g]),
            .cpu_stall  (cpu_stall[g]),
            .host_req   (host_req[g]),
            .host_we    (host_we[g]),
            .host_addr  (host_addr[g]),
            .host_wdata (host_wdata[g]),
            .host_gnt   (host_gnt[g]),
            .host_rvalid(host_rvalid[g]),
            .host_rdata (host_rdata[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with registered read data; contents reload a known pattern while reset is held.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                mem_rdata[i] <= '0;
                for (int k = 0; k < 16; k++) tbmem[i][k] <= 32'hA5A5_0000 | 32'(k);
            end else if (mem_en[i]) begin
                if (mem_we[i]) tbmem[i][mem_addr[i][5:2]] <= mem_wdata[i];
                else           mem_rdata[i] <= tbmem[i][mem_addr[i][5:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            free_at[i]   = cyc;
            iss_cyc[i]   = -100;
            h_lost[i]    = 0;
            last_host[i] = 1'b1;
            for (int k = 0; k < 16; k++) shadow[i][k] = 32'hA5A5_0000 | 32'(k);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.p%0d.mem_en", tag, i), mem_en[i], 0);
            check($sformatf("%s.p%0d.mem_we", tag, i), mem_we[i], 0);
            check($sformatf("%s.p%0d.mem_addr", tag, i), mem_addr[i], 0);
            check($sformatf("%s.p%0d.mem_wdata", tag, i), mem_wdata[i], 0);
            check($sformatf("%s.p%0d.gnt", tag, i), {cpu_gnt[i], host_gnt[i]}, 0);
            check($sformatf("%s.p%0d.rvalid", tag, i), {cpu_rvalid[i], host_rvalid[i]}, 0);
            check($sformatf("%s.p%0d.cpu_rdata", tag, i), cpu_rdata[i], 0);
            check($sformatf("%s.p%0d.host_rdata", tag, i), host_rdata[i], 0);
            check($sformatf("%s.p%0d.stall", tag, i), cpu_stall[i], 0);
        end
    endtask

    task automatic drive_port(input int i, input bit host, input bit req);
        logic        we;
        logic [31:0] a, wd;
        we = 1'($urandom_range(1));
        a  = 32'($urandom_range(15)) << 2;
        wd = $urandom;
        if (host) begin
            host_req[i] = req; host_we[i] = we; host_addr[i] = a; host_wdata[i] = wd;
        end else begin
            cpu_req[i] = req; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = wd;
        end
    endtask

    task automatic step();
        bit          en, rv, cg, hg, c, h, hw, we;
        logic [31:0] a, wd;
        for (int i = 0; i < 2; i++) begin
            cg = (iss_cyc[i] == cyc - 1) && !iss_host[i];
            hg = (iss_cyc[i] == cyc - 1) && iss_host[i];
            if (cg) drive_port(i, 0, hold_on | (rnd_on && $urandom_range(3) != 0));
            else if (rnd_on && !cpu_req[i] && $urandom_range(2) == 0) drive_port(i, 0, 1);
            if (hg) drive_port(i, 1, hold_on | (rnd_on && $urandom_range(3) != 0));
            else if (rnd_on && !host_req[i] && $urandom_range(2) == 0) drive_port(i, 1, 1);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            en = (iss_cyc[i] == cyc);
            rv = (iss_cyc[i] == cyc - 1) && !iss_we[i];
            cg = en && !iss_host[i];
            check($sformatf("p%0d.mem_en", i), mem_en[i], en);
            check($sformatf("p%0d.mem_we", i), mem_we[i], en && iss_we[i]);
            check($sformatf("p%0d.mem_addr", i), mem_addr[i], en ? iss_addr[i] : 0);
            check($sformatf("p%0d.mem_wdata", i), mem_wdata[i], en ? iss_wd[i] : 0);
            check($sformatf("p%0d.cpu_gnt", i), cpu_gnt[i], cg);
            check($sformatf("p%0d.host_gnt", i), host_gnt[i], en && iss_host[i]);
            check($sformatf("p%0d.cpu_rvalid", i), cpu_rvalid[i], rv && !iss_host[i]);
            check($sformatf("p%0d.host_rvalid", i), host_rvalid[i], rv && iss_host[i]);
            check($sformatf("p%0d.cpu_rdata", i), cpu_rdata[i], (rv && !iss_host[i]) ? rsp_data[i] : 0);
            check($sformatf("p%0d.host_rdata", i), host_rdata[i], (rv && iss_host[i]) ? rsp_data[i] : 0);
            check($sformatf("p%0d.cpu_stall", i), cpu_stall[i],
                  cpu_req[i] && !(cg && cpu_we[i]) && !(rv && !iss_host[i]));
            if (rec && gcnt[i] < 10 && (cpu_gnt[i] || host_gnt[i])) begin
                gseq[i] = {gseq[i][8:0], host_gnt[i]};
                gcnt[i]++;
            end
            if (cyc >= free_at[i]) begin
                c  = cpu_req[i];
                h  = host_req[i];
                hw = h && (!c || (i == 1 ? !last_host[i] : h_lost[i] == LIM));
                if (!h || hw) h_lost[i] = 0;
                else if (c)   h_lost[i] = (h_lost[i] + 1 > LIM) ? LIM : h_lost[i] + 1;
                if (c || h) begin
                    we = hw ? host_we[i] : cpu_we[i];
                    a  = hw ? host_addr[i] : cpu_addr[i];
                    wd = hw ? host_wdata[i] : cpu_wdata[i];
                    last_host[i] = hw;
                    iss_cyc[i]   = cyc + 1;
                    iss_host[i]  = hw;
                    iss_we[i]    = we;
                    iss_addr[i]  = a;
                    iss_wd[i]    = wd;
                    if (we) shadow[i][a[5:2]] = wd;
                    else    rsp_data[i] = shadow[i][a[5:2]];
                    free_at[i] = cyc + (we ? 2 : 3);
                end
            end
        end
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        hold_on = 0; rnd_on = 0; rec = 0;
        rst = 1'b0;
        cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        host_req = '0; host_we = '0; host_addr = '0; host_wdata = '0;
        gseq[0] = '0; gseq[1] = '0; gcnt[0] = 0; gcnt[1] = 0;
        repeat (2) tick();
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        tick();
        model_reset();

        // Both ports request back to back from reset.
        hold_on = 1; rec = 1;
        for (int i = 0; i < 2; i++) begin
            drive_port(i, 0, 1);
            drive_port(i, 1, 1);
        end
        repeat (40) step();
        rec = 0;
        for (int i = 0; i < 2; i++) check($sformatf("p%0d.grant_count", i), gcnt[i], 10);
        check("p0.order_CCCCHCCCCH", gseq[0], 10'b0000100001);
        check("p1.order_CHCHCHCHCH", gseq[1], 10'b0101010101);

        hold_on = 0; rnd_on = 1;
        repeat (300) step();
        rnd_on = 0;
        repeat (12) step();
        repeat (10) step();

        // Host read to 0x4, reset asserted during its ISSUE cycle.
        for (int i = 0; i < 2; i++) begin
            host_req[i] = 1'b1; host_we[i] = 1'b0; host_addr[i] = 32'h4; host_wdata[i] = $urandom;
        end
        step();
        #1 rst = 1'b0;
        #1 chk_zero("mid_reset");
        host_req = '0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        model_reset();
        repeat (4) step();
        for (int i = 0; i < 2; i++) begin
            host_req[i] = 1'b1; host_we[i] = 1'b0; host_addr[i] = 32'h4;
        end
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
